// File: rtl/board_pkg.sv
// rtl/board_pkg.sv - shared constants, cell format, address type and FSM states for the board memory
package board_pkg;

    localparam int MAX_DIM = 16;
    localparam int DATA_W  = 8;
    localparam int HALF_W  = $clog2(MAX_DIM);
    localparam int ADR_W   = 2 * HALF_W;
    localparam int DIM_W   = HALF_W + 1;
    localparam int CELLS   = MAX_DIM * MAX_DIM;

    typedef logic [ADR_W-1:0] cell_adr_t;

    typedef struct packed {
        logic       reserved;
        logic       flagged;
        logic       revealed;
        logic       mine;
        logic [3:0] count;
    } cell_t;

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_ACK
    } state_t;

    // Address is {row, col}; a cell exists only if both are below the active side.
    function automatic logic in_range(cell_adr_t adr, logic [DIM_W-1:0] dim);
        logic [DIM_W-1:0] row;
        logic [DIM_W-1:0] col;
        row = DIM_W'(adr[ADR_W-1 -: HALF_W]);
        col = DIM_W'(adr[HALF_W-1:0]);
        return (row < dim) && (col < dim);
    endfunction

endpackage

// File: rtl/board_wb_slave_if.sv
// rtl/board_wb_slave_if.sv - Wishbone classic bus bundle with master and slave views
// Signals are named from the slave side: *_i driven by the master, *_o by the slave.
interface wishbone_if #(
    parameter int ADR_W  = 8,
    parameter int DATA_W = 8
);
    logic              cyc_i;
    logic              stb_i;
    logic              we_i;
    logic [ADR_W-1:0]  adr_i;
    logic [DATA_W-1:0] dat_i;
    logic [DATA_W-1:0] dat_o;
    logic              ack_o;

    modport slave  (input  cyc_i, stb_i, we_i, adr_i, dat_i, output dat_o, ack_o);
    modport master (output cyc_i, stb_i, we_i, adr_i, dat_i, input  dat_o, ack_o);
endinterface

// File: rtl/board_cell_ram.sv
// rtl/board_cell_ram.sv - single-port synchronous cell RAM with registered read
// Ports: clk; we/adr/wdat write request; rdat = contents of adr at the previous edge.
module board_cell_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = 8,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] adr,
    input  logic [DW-1:0] wdat,
    output logic [DW-1:0] rdat
);
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdat_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[adr] <= wdat;
        end
        rdat_q <= mem[adr];
    end

    assign rdat = rdat_q;
endmodule

// File: rtl/board_wb_slave.sv
// rtl/board_wb_slave.sv - Wishbone classic responder owning the board cell memory
// Ports: clk, rst_n (async, active-low); board_dim active side; clear_req sweep request;
// gl_we/gl_adr/gl_dat priority direct write; busy high while sweeping; board_wb Wishbone slave.
module board_wb_slave
    import board_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DIM_W-1:0]  board_dim,
    input  logic              clear_req,
    input  logic              gl_we,
    input  cell_adr_t         gl_adr,
    input  logic [DATA_W-1:0] gl_dat,
    output logic              busy,
    wishbone_if.slave         board_wb
);
    state_t            state_q,    state_d;
    cell_adr_t         clr_cnt_q,  clr_cnt_d;
    logic              clr_pend_q, clr_pend_d;
    logic              req_rd_q,   req_rd_d;
    logic [DATA_W-1:0] dat_q,      dat_d;

    logic              ram_we;
    cell_adr_t         ram_adr;
    logic [DATA_W-1:0] ram_wdat;
    logic [DATA_W-1:0] ram_rdat;
    logic [DATA_W-1:0] rd_val;

    board_cell_ram #(
        .DEPTH(CELLS),
        .AW   (ADR_W),
        .DW   (DATA_W)
    ) u_ram (
        .clk (clk),
        .we  (ram_we),
        .adr (ram_adr),
        .wdat(ram_wdat),
        .rdat(ram_rdat)
    );

    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        clr_pend_d = clr_pend_q;
        req_rd_d   = req_rd_q;
        dat_d      = dat_q;
        ram_we     = 1'b0;
        ram_adr    = board_wb.adr_i;
        ram_wdat   = board_wb.dat_i;
        // Writes and out-of-range reads return zero; only an in-range read shows RAM data.
        rd_val     = req_rd_q ? ram_rdat : '0;

        case (state_q)
            ST_CLEAR: begin
                ram_we     = 1'b1;
                ram_adr    = clr_cnt_q;
                ram_wdat   = '0;
                clr_cnt_d  = clr_cnt_q + 1'b1;
                clr_pend_d = 1'b0;
                if (clr_cnt_q == cell_adr_t'(CELLS - 1)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (clear_req || clr_pend_q) begin
                    state_d    = ST_CLEAR;
                    clr_cnt_d  = '0;
                    clr_pend_d = 1'b0;
                end else if (gl_we) begin
                    ram_adr  = gl_adr;
                    ram_wdat = gl_dat;
                    ram_we   = in_range(gl_adr, board_dim);
                end else if (board_wb.cyc_i && board_wb.stb_i) begin
                    ram_we   = board_wb.we_i && in_range(board_wb.adr_i, board_dim);
                    req_rd_d = !board_wb.we_i && in_range(board_wb.adr_i, board_dim);
                    state_d  = ST_ACK;
                end
            end
            ST_ACK: begin
                // The RAM read port is free here, so the direct write port is still served.
                dat_d   = rd_val;
                state_d = ST_IDLE;
                if (clear_req) begin
                    clr_pend_d = 1'b1;
                end
                if (gl_we) begin
                    ram_adr  = gl_adr;
                    ram_wdat = gl_dat;
                    ram_we   = in_range(gl_adr, board_dim);
                end
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_CLEAR;
            clr_cnt_q  <= '0;
            clr_pend_q <= 1'b0;
            req_rd_q   <= 1'b0;
            dat_q      <= '0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            clr_pend_q <= clr_pend_d;
            req_rd_q   <= req_rd_d;
            dat_q      <= dat_d;
        end
    end

    // Read data lands in the RAM output register during ACK; dat_q keeps it afterwards.
    assign board_wb.ack_o = (state_q == ST_ACK);
    assign board_wb.dat_o = (state_q == ST_ACK) ? rd_val : dat_q;
    assign busy           = (state_q == ST_CLEAR);
endmodule

// File: tb/tb_board_wb_slave.sv
// tb/tb_board_wb_slave.sv - self-checking bench for board_wb_slave
module tb_board_wb_slave;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] board_dim;
    logic       clear_req;
    logic       gl_we;
    logic [7:0] gl_adr;
    logic [7:0] gl_dat;
    logic       busy;

    int checks = 0;
    int errors = 0;

    wishbone_if #(.ADR_W(8), .DATA_W(8)) wb ();

    board_wb_slave dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .board_dim(board_dim),
        .clear_req(clear_req),
        .gl_we    (gl_we),
        .gl_adr   (gl_adr),
        .gl_dat   (gl_dat),
        .busy     (busy),
        .board_wb (wb)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         we;
        logic [7:0] adr;
        logic [7:0] wdat;
        logic [4:0] dim;
        int         gl_k;
        logic [7:0] gl_adr;
        logic [7:0] gl_dat;
        logic [7:0] exp_dat;
        int         exp_lat;
    } vec_t;

    typedef struct {
        logic [7:0] adr;
        logic [7:0] exp_dat;
        int         exp_lat;
    } sb_t;

    vec_t vecs [22];
    sb_t  sb_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One Wishbone transfer, optionally with gl_we held for gl_k cycles from the request cycle.
    task automatic wb_xfer(input bit we, input logic [7:0] adr, input logic [7:0] wdat,
                           input logic [4:0] dim, input int gl_k, input logic [7:0] gadr,
                           input logic [7:0] gdat, input logic [7:0] exp_dat,
                           input int exp_lat, input int budget);
        sb_t e;
        int  n;
        bit  got;
        @(posedge clk); #1;
        board_dim = dim;
        sb_q.push_back('{adr, exp_dat, exp_lat});
        wb.cyc_i = 1'b1;
        wb.stb_i = 1'b1;
        wb.we_i  = we;
        wb.adr_i = adr;
        wb.dat_i = wdat;
        if (gl_k > 0) begin
            gl_we  = 1'b1;
            gl_adr = gadr;
            gl_dat = gdat;
        end
        n   = 0;
        got = 1'b0;
        while (!got && n < budget) begin
            @(posedge clk); #1;
            n++;
            if (n >= gl_k) gl_we = 1'b0;
            if (wb.ack_o) got = 1'b1;
        end
        gl_we    = 1'b0;
        wb.cyc_i = 1'b0;
        wb.stb_i = 1'b0;
        wb.we_i  = 1'b0;
        e = sb_q.pop_front();
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout adr=%02h: no ack within %0d cycles, expected latency %0d",
                     e.adr, budget, e.exp_lat);
        end else begin
            chk($sformatf("dat_o adr=%02h", e.adr), 32'(wb.dat_o), 32'(e.exp_dat));
            chk($sformatf("ack_lat adr=%02h", e.adr), 32'(n), 32'(e.exp_lat));
        end
    endtask

    task automatic count_sweep(input string name);
        int n;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (busy && n < 400);
        chk(name, 32'(n), 32'd256);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{1'b1, 8'h23, 8'h15, 5'd10, 0, 8'h00, 8'h00, 8'h00, 1};
        vecs[1]  = '{1'b0, 8'h23, 8'h00, 5'd10, 0, 8'h00, 8'h00, 8'h15, 1};
        vecs[2]  = '{1'b0, 8'h2A, 8'h00, 5'd10, 0, 8'h00, 8'h00, 8'h00, 1};
        vecs[3]  = '{1'b1, 8'hA0, 8'h77, 5'd10, 0, 8'h00, 8'h00, 8'h00, 1};
        vecs[4]  = '{1'b0, 8'hA0, 8'h00, 5'd10, 0, 8'h00, 8'h00, 8'h00, 1};
        vecs[5]  = '{1'b0, 8'hA0, 8'h00, 5'd16, 0, 8'h00, 8'h00, 8'h00, 1};
        vecs[6]  = '{1'b1, 8'h99, 8'hFF, 5'd10, 0, 8'h00, 8'h00, 8'h00, 1};
        vecs[7]  = '{1'b0, 8'h99, 8'h00, 5'd10, 0, 8'h00, 8'h00, 8'hFF, 1};
        vecs[8]  = '{1'b1, 8'hFF, 8'h5A, 5'd16, 0, 8'h00, 8'h00, 8'h00, 1};
        vecs[9]  = '{1'b0, 8'hFF, 8'h00, 5'd16, 0, 8'h00, 8'h00, 8'h5A, 1};
        vecs[10] = '{1'b0, 8'hFF, 8'h00, 5'd15, 0, 8'h00, 8'h00, 8'h00, 1};
        vecs[11] = '{1'b1, 8'h00, 8'h81, 5'd1,  0, 8'h00, 8'h00, 8'h00, 1};
        vecs[12] = '{1'b0, 8'h00, 8'h00, 5'd1,  0, 8'h00, 8'h00, 8'h81, 1};
        vecs[13] = '{1'b0, 8'h01, 8'h00, 5'd1,  0, 8'h00, 8'h00, 8'h00, 1};
        vecs[14] = '{1'b0, 8'h10, 8'h00, 5'd1,  0, 8'h00, 8'h00, 8'h00, 1};
        vecs[15] = '{1'b0, 8'h11, 8'h00, 5'd16, 1, 8'h11, 8'h30, 8'h30, 2};
        vecs[16] = '{1'b0, 8'h11, 8'h00, 5'd16, 3, 8'h12, 8'h2C, 8'h30, 4};
        vecs[17] = '{1'b0, 8'h12, 8'h00, 5'd16, 0, 8'h00, 8'h00, 8'h2C, 1};
        vecs[18] = '{1'b0, 8'hB3, 8'h00, 5'd10, 1, 8'hB3, 8'h07, 8'h00, 2};
        vecs[19] = '{1'b0, 8'hB3, 8'h00, 5'd16, 0, 8'h00, 8'h00, 8'h00, 1};
        vecs[20] = '{1'b1, 8'h11, 8'h3F, 5'd16, 2, 8'h11, 8'h01, 8'h00, 3};
        vecs[21] = '{1'b0, 8'h11, 8'h00, 5'd16, 0, 8'h00, 8'h00, 8'h3F, 1};

        rst_n     = 1'b0;
        board_dim = 5'd16;
        clear_req = 1'b0;
        gl_we     = 1'b0;
        gl_adr    = 8'h00;
        gl_dat    = 8'h00;
        wb.cyc_i  = 1'b0;
        wb.stb_i  = 1'b0;
        wb.we_i   = 1'b0;
        wb.adr_i  = 8'h00;
        wb.dat_i  = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", 32'(busy), 32'd1);
        chk("reset ack_o", 32'(wb.ack_o), 32'd0);
        chk("reset dat_o", 32'(wb.dat_o), 32'd0);
        rst_n = 1'b1;
        count_sweep("initial sweep cycles");

        for (int a = 0; a < 256; a++) begin
            wb_xfer(1'b0, 8'(a), 8'h00, 5'd16, 0, 8'h00, 8'h00, 8'h00, 1, 10);
        end

        for (int i = 0; i < 22; i++) begin
            wb_xfer(vecs[i].we, vecs[i].adr, vecs[i].wdat, vecs[i].dim, vecs[i].gl_k,
                    vecs[i].gl_adr, vecs[i].gl_dat, vecs[i].exp_dat, vecs[i].exp_lat, 10);
        end

        // Master drops cyc during ACK of a write: one ack pulse, write stands.
        @(posedge clk); #1;
        board_dim = 5'd16;
        wb.cyc_i = 1'b1;
        wb.stb_i = 1'b1;
        wb.we_i  = 1'b1;
        wb.adr_i = 8'h00;
        wb.dat_i = 8'h50;
        @(posedge clk); #1;
        wb.cyc_i = 1'b0;
        wb.stb_i = 1'b0;
        wb.we_i  = 1'b0;
        #1;
        chk("abort ack pulse", 32'(wb.ack_o), 32'd1);
        @(posedge clk); #1;
        chk("abort ack single", 32'(wb.ack_o), 32'd0);
        wb_xfer(1'b0, 8'h00, 8'h00, 5'd16, 0, 8'h00, 8'h00, 8'h50, 1, 10);

        // clear_req during the ACK of a read.
        wb_xfer(1'b1, 8'h05, 8'h42, 5'd16, 0, 8'h00, 8'h00, 8'h00, 1, 10);
        wb_xfer(1'b0, 8'h05, 8'h00, 5'd16, 0, 8'h00, 8'h00, 8'h42, 1, 10);
        clear_req = 1'b1;
        @(posedge clk); #1;
        clear_req = 1'b0;
        chk("busy idle after ack", 32'(busy), 32'd0);
        wb_xfer(1'b0, 8'h05, 8'h00, 5'd16, 0, 8'h00, 8'h00, 8'h00, 257, 400);
        wb_xfer(1'b0, 8'hFF, 8'h00, 5'd16, 0, 8'h00, 8'h00, 8'h00, 1, 10);
        wb_xfer(1'b0, 8'h00, 8'h00, 5'd16, 0, 8'h00, 8'h00, 8'h00, 1, 10);

        // Reset in the middle of an ACK.
        wb_xfer(1'b1, 8'h23, 8'h15, 5'd16, 0, 8'h00, 8'h00, 8'h00, 1, 10);
        @(posedge clk); #1;
        wb.cyc_i = 1'b1;
        wb.stb_i = 1'b1;
        wb.we_i  = 1'b0;
        wb.adr_i = 8'h23;
        @(posedge clk); #1;
        chk("pre-reset ack_o", 32'(wb.ack_o), 32'd1);
        chk("pre-reset dat_o", 32'(wb.dat_o), 32'h15);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset ack_o", 32'(wb.ack_o), 32'd0);
        chk("async reset dat_o", 32'(wb.dat_o), 32'd0);
        chk("async reset busy", 32'(busy), 32'd1);
        wb.cyc_i = 1'b0;
        wb.stb_i = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        count_sweep("sweep after ack reset");

        // Reset with the sweep counter at 100.
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (100) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid-clear reset busy", 32'(busy), 32'd1);
        chk("mid-clear reset ack_o", 32'(wb.ack_o), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        count_sweep("sweep after clear reset");
        wb_xfer(1'b0, 8'h23, 8'h00, 5'd16, 0, 8'h00, 8'h00, 8'h00, 1, 10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/board_wb_slave.md
Name: board_wb_slave

Overview:
- Wishbone classic responder that owns the board cell memory.
- Board drawing and game logic read this memory as Wishbone masters.
- Serves single reads and writes of one cell byte each, plus a direct high-priority write port for the game-logic engine.
- Sweeps the whole memory to zero after reset or on request, so each new game starts from a clean board.

Parameters:
- MAX_DIM, 16, maximum board side in cells (power of 2).
- DATA_W, 8, cell word width.
- ADR_W, 8, Wishbone address width; equals 2*log2(MAX_DIM).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- board_dim  in  5  active board side, 1..MAX_DIM; sampled every cycle.
- clear_req  in  1  one-cycle pulse: zero the memory.
- gl_we  in  1  game-logic direct write strobe.
- gl_adr  in  ADR_W  direct write address {row[3:0], col[3:0]}.
- gl_dat  in  DATA_W  direct write data.
- busy  out  1  high while clearing.
- board_wb  wishbone_if.slave  ADR_W/DATA_W  Wishbone classic slave:
  - cyc_i, stb_i, we_i: bus cycle, strobe, write enable.
  - adr_i[ADR_W-1:0] = {row, col}.
  - dat_i, dat_o: write and read data.
  - ack_o: transfer acknowledge.

Behaviour:
- Cell format:
  - bits[3:0] neighbour mine count.
  - bit4 mine.
  - bit5 revealed.
  - bit6 flagged.
  - bit7 reserved; written as given, read back as stored.
- Reset (rst_n low, asynchronous):
  - ack_o=0, dat_o=0, busy=1.
  - state=CLEAR, clr_cnt=0.
  - Memory contents are not reset directly; the CLEAR sweep zeroes them.
- FSM states: CLEAR, IDLE, ACK.
  - CLEAR:
    - Writes 0 to address clr_cnt each cycle; clr_cnt increments.
    - Covers all MAX_DIM*MAX_DIM entries regardless of board_dim (256 cycles at default).
    - After writing the last address: busy=0 on the next cycle, go to IDLE.
    - Wishbone requests are stalled (no ack) during CLEAR.
    - gl_we is dropped during CLEAR.
  - IDLE, in priority order:
    - clear_req → CLEAR, clr_cnt=0.
    - Else gl_we → write gl_dat at gl_adr; any pending Wishbone request waits in IDLE.
    - Else cyc_i&stb_i → accept. Write: memory updated at this edge. Read: memory read registered. Go to ACK.
  - ACK:
    - ack_o=1 for exactly one cycle; dat_o holds the read data (reads) or 0 (writes).
    - Returns to IDLE.
    - A clear_req arriving in ACK is held and taken in the following IDLE cycle.
- Latency:
  - Request first seen in IDLE at cycle N with no gl_we → ack_o high in cycle N+1.
  - Back-to-back transfers take 2 cycles each.
  - gl_we held for k cycles delays the Wishbone ack by k cycles.
- Range check (row or col >= board_dim):
  - Read returns 0.
  - Write is ignored.
  - The access is still acked with normal timing.
  - gl_we to an out-of-range address is ignored.
- Abort: if cyc_i drops during ACK, ack_o still pulses once and a completed write stands.
- dat_o holds its value between acks.
- A write and a read of the same cell are never concurrent: one access per cycle, so no bypass is needed.
- Reset mid-CLEAR or mid-ACK: immediate return to the reset state; the sweep restarts from address 0.

Decomposition:
- Package board_pkg:
  - cell_t packed struct {reserved, flagged, revealed, mine, count[3:0]}.
  - MAX_DIM, cell address typedef.
  - FSM enum.
- Sub-module board_cell_ram:
  - Single-port synchronous RAM, MAX_DIM*MAX_DIM x DATA_W, registered read.
  - Port mux (clear / gl / Wishbone) stays in board_wb_slave.

Test Plan:
- Reset release → busy=1 for 256 cycles then 0. Every address in 0x00..0xFF reads 0x00 with ack one cycle after stb.
- board_dim=10: WB write 0x15 to adr 0x23, then read adr 0x23 → dat_o=0x15, ack_o one cycle each. Read adr 0x2A (col 10) → 0x00; write to 0xA0 is ignored (re-read gives 0).
- gl_we with gl_adr=0x11, gl_dat=0x30 in the same cycle a WB read of 0x11 arrives → WB ack delayed one cycle, dat_o=0x30.
- clear_req pulse during ACK of a read → the ack completes with the correct data, then busy=1. WB stb during the clear gets no ack until busy falls, then reads 0x00.
- rst_n pulled low at clr_cnt=100 → ack_o=0 and busy=1 asynchronously; after release the sweep takes the full 256 cycles.
- cyc_i dropped during ACK of a write 0x50 to 0x00 → single ack pulse; a later read of 0x00 returns 0x50.
